// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetches through MAR/MDR into IR, then steps
// register-register ALU and MUL/DIV instructions, with a bounded wait on memory reads.
module control_unit #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        run,
  output logic        PCOut,
  output logic        MARIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        MDRead,
  output logic        MDROut,
  output logic        IRIn,
  output logic        RYIn,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        LOWIn,
  output logic        HIIn,
  output logic [3:0]  reg_sel,
  output logic        reg_out,
  output logic        reg_in,
  output logic [3:0]  ALUcontrol,
  output logic        done,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned CntW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] WaitOne  = CntW'(1);
  localparam logic [CntW-1:0] WaitLast = CntW'(STALL_LIMIT - 1);

  localparam logic [3:0] StRst  = 4'd0;
  localparam logic [3:0] StIdle = 4'd1;
  localparam logic [3:0] StT0   = 4'd2;
  localparam logic [3:0] StT1   = 4'd3;
  localparam logic [3:0] StT2   = 4'd4;
  localparam logic [3:0] StT3   = 4'd5;
  localparam logic [3:0] StT4   = 4'd6;
  localparam logic [3:0] StT5   = 4'd7;
  localparam logic [3:0] StT6   = 4'd8;
  localparam logic [3:0] StHlt  = 4'd9;

  localparam logic [4:0] OpMul  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpHalt = 5'b11011;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            t1_first_q, t1_first_d;
  logic            is_md_q, is_md_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       op_alu, op_md, op_halt, op_legal;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign op_alu   = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign op_md    = (opcode == OpMul) || (opcode == OpDiv);
  assign op_halt  = (opcode == OpHalt);
  assign op_legal = op_alu || op_md;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRst;
      wait_q     <= '0;
      t1_first_q <= 1'b0;
      is_md_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      t1_first_q <= t1_first_d;
      is_md_q    <= is_md_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    t1_first_d = 1'b0;
    is_md_d    = is_md_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    case (state_q)
      StRst, StIdle: begin
        if (run) state_d = StT0;
      end
      StT0: begin
        state_d    = StT1;
        wait_d     = '0;
        t1_first_d = 1'b1;
      end
      StT1: begin
        // PC was already bumped on T1 entry, so a timeout abandons the fetch as-is.
        if (mem_ready) begin
          state_d = StT2;
        end else if (wait_q == WaitLast) begin
          state_d = StIdle;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitOne;
        end
      end
      StT2: state_d = StT3;
      StT3: begin
        if (op_halt) begin
          state_d  = StHlt;
          halted_d = 1'b1;
        end else if (op_legal) begin
          state_d = StT4;
          is_md_d = op_md;
        end else begin
          state_d = StIdle;
          fault_d = 1'b1;
        end
      end
      StT4: state_d = StT5;
      StT5: begin
        if (is_md_q) state_d = StT6;
        else         state_d = run ? StT0 : StIdle;
      end
      StT6:  state_d = run ? StT0 : StIdle;
      StHlt: state_d = StHlt;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    PCOut      = 1'b0;
    MARIn      = 1'b0;
    PCIn       = 1'b0;
    MDRIn      = 1'b0;
    MDRead     = 1'b0;
    MDROut     = 1'b0;
    IRIn       = 1'b0;
    RYIn       = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    ZLowOut    = 1'b0;
    ZHighOut   = 1'b0;
    LOWIn      = 1'b0;
    HIIn       = 1'b0;
    reg_sel    = 4'd0;
    reg_out    = 1'b0;
    reg_in     = 1'b0;
    ALUcontrol = 4'd0;
    done       = 1'b0;
    case (state_q)
      StT0: begin
        PCOut      = 1'b1;
        MARIn      = 1'b1;
        ZLowIn     = 1'b1;
        ALUcontrol = 4'b0001;
      end
      StT1: begin
        ZLowOut = 1'b1;
        PCIn    = t1_first_q;
        MDRead  = 1'b1;
        MDRIn   = 1'b1;
      end
      StT2: begin
        MDROut = 1'b1;
        IRIn   = 1'b1;
      end
      StT3: begin
        if (op_legal) begin
          reg_sel = rb;
          reg_out = 1'b1;
          RYIn    = 1'b1;
        end
      end
      StT4: begin
        reg_sel    = rc;
        reg_out    = 1'b1;
        ALUcontrol = opcode[3:0];
        ZLowIn     = 1'b1;
        ZHighIn    = is_md_q;
      end
      StT5: begin
        ZLowOut = 1'b1;
        if (is_md_q) begin
          LOWIn = 1'b1;
        end else begin
          reg_sel = ra;
          reg_in  = 1'b1;
          done    = 1'b1;
        end
      end
      StT6: begin
        ZHighOut = 1'b1;
        HIIn     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = halted_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction summary table, hand-written reset sequence,
// and a random instruction stream checked cycle by cycle against a trace model.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] IR;
  logic        mem_ready;
  logic        run;
  logic PCOut, MARIn, PCIn, MDRIn, MDRead, MDROut, IRIn, RYIn;
  logic ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOWIn, HIIn;
  logic [3:0] reg_sel;
  logic reg_out, reg_in;
  logic [3:0] ALUcontrol;
  logic done, halted, fault;

  control_unit #(.STALL_LIMIT(15)) dut (
    .clk(clk), .reset(reset), .IR(IR), .mem_ready(mem_ready), .run(run),
    .PCOut(PCOut), .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .MDRead(MDRead),
    .MDROut(MDROut), .IRIn(IRIn), .RYIn(RYIn), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOWIn(LOWIn), .HIIn(HIIn),
    .reg_sel(reg_sel), .reg_out(reg_out), .reg_in(reg_in), .ALUcontrol(ALUcontrol),
    .done(done), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_out, mar_in, pc_in, mdr_in, md_read, mdr_out, ir_in, ry_in;
    logic zl_in, zh_in, zl_out, zh_out, lo_in, hi_in, r_out, r_in;
    logic [3:0] sel;
    logic [3:0] alu;
    logic done, halted, fault;
  } ov_t;

  typedef struct {
    ov_t         o;
    bit          mr;
    bit          rn;
    bit          new_ir;
    logic [31:0] ir;
  } cyc_t;

  typedef struct {
    logic [31:0] ir;
    int          stall;     // >= 15 means memory never answers
    int          done_at;   // cycle index from T0, -1 if done must never pulse
    int          n_irin;
    int          n_mdread;
    bit          fault;
    bit          halted;
  } row_t;

  int   checks = 0;
  int   errors = 0;
  cyc_t cq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ov_t sample();
    ov_t v;
    v.pc_out = PCOut;  v.mar_in = MARIn;  v.pc_in = PCIn;     v.mdr_in = MDRIn;
    v.md_read = MDRead; v.mdr_out = MDROut; v.ir_in = IRIn;   v.ry_in = RYIn;
    v.zl_in = ZLowIn;  v.zh_in = ZHighIn; v.zl_out = ZLowOut; v.zh_out = ZHighOut;
    v.lo_in = LOWIn;   v.hi_in = HIIn;    v.r_out = reg_out;  v.r_in = reg_in;
    v.sel = reg_sel;   v.alu = ALUcontrol;
    v.done = done;     v.halted = halted; v.fault = fault;
    return v;
  endfunction

  function automatic ov_t strobes_only(input ov_t v);
    ov_t s = v;
    s.halted = 1'b0;
    s.fault  = 1'b0;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; IR = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_state", sample(), '0);
  endtask

  function automatic void push(input ov_t o, input bit mr, input bit rn, input bit ni,
                               input logic [31:0] ir);
    cyc_t c;
    c.o = o; c.mr = mr; c.rn = rn; c.new_ir = ni; c.ir = ir;
    cq.push_back(c);
  endfunction

  // Expected per-cycle trace of one legal ALU/MUL/DIV instruction.
  function automatic void add_instr(input logic [31:0] ir, input int stall, input bit last);
    ov_t v;
    bit  md = (ir[31:27] == 5'd14) || (ir[31:27] == 5'd15);
    bit  rn_end = !last;
    v = '0; v.pc_out = 1; v.mar_in = 1; v.zl_in = 1; v.alu = 4'd1;
    push(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, ir);
    for (int k = 0; k <= stall; k++) begin
      v = '0; v.zl_out = 1; v.md_read = 1; v.mdr_in = 1; v.pc_in = (k == 0);
      push(v, (k == stall), 1'($urandom_range(0, 1)), 1'b0, ir);
    end
    v = '0; v.mdr_out = 1; v.ir_in = 1;
    push(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, ir);
    v = '0; v.sel = ir[22:19]; v.r_out = 1; v.ry_in = 1;
    push(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, ir);
    v = '0; v.sel = ir[18:15]; v.r_out = 1; v.alu = ir[30:27]; v.zl_in = 1; v.zh_in = md;
    push(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, ir);
    if (!md) begin
      v = '0; v.zl_out = 1; v.sel = ir[26:23]; v.r_in = 1; v.done = 1;
      push(v, 1'($urandom_range(0, 1)), rn_end, 1'b0, ir);
    end else begin
      v = '0; v.zl_out = 1; v.lo_in = 1;
      push(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, ir);
      v = '0; v.zh_out = 1; v.hi_in = 1; v.done = 1;
      push(v, 1'($urandom_range(0, 1)), rn_end, 1'b0, ir);
    end
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    row_t rows[12];
    ov_t  v, e;
    rows[0]  = '{32'h19890000,  0,  5, 1,  1, 0, 0};  // ADD R3,R1,R2
    rows[1]  = '{32'h70228000,  0,  6, 1,  1, 0, 0};  // MUL R4,R5
    rows[2]  = '{32'h19890000,  3,  8, 1,  4, 0, 0};
    rows[3]  = '{32'h7A4A0000,  2,  8, 1,  3, 0, 0};  // DIV
    rows[4]  = '{32'h5C480000,  0,  5, 1,  1, 0, 0};  // top of ALU range
    rows[5]  = '{32'hD8000000,  0, -1, 1,  1, 0, 1};  // HALT
    rows[6]  = '{32'hF8000000,  0, -1, 1,  1, 1, 0};
    rows[7]  = '{32'h00000000,  1, -1, 1,  2, 1, 0};
    rows[8]  = '{32'h60000000,  0, -1, 1,  1, 1, 0};  // opcode 12
    rows[9]  = '{32'h68000000,  0, -1, 1,  1, 1, 0};  // opcode 13
    rows[10] = '{32'h19890000, 14, 19, 1, 15, 0, 0};  // one short of timeout
    rows[11] = '{32'h19890000, 99, -1, 0, 15, 1, 0};  // timeout

    foreach (rows[r]) begin
      int n_done, done_at, n_irin, n_pcin, n_mdread, hlt_bad;
      n_done = 0; done_at = -1; n_irin = 0; n_pcin = 0; n_mdread = 0; hlt_bad = 0;
      do_reset();
      IR  = rows[r].ir;
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int c = 0; c < 40; c++) begin
        mem_ready = (c >= 1) && (c - 1 >= rows[r].stall);
        #1;
        v = sample();
        if (v.done) begin
          n_done++;
          if (done_at < 0) done_at = c;
        end
        n_irin   += int'(v.ir_in);
        n_pcin   += int'(v.pc_in);
        n_mdread += int'(v.md_read);
        if (v.halted && strobes_only(v) != '0) hlt_bad++;
        tick();
      end
      chk($sformatf("row%0d_done_cnt", r), n_done, (rows[r].done_at >= 0) ? 1 : 0);
      chk($sformatf("row%0d_done_at", r), done_at, rows[r].done_at);
      chk($sformatf("row%0d_irin_cnt", r), n_irin, rows[r].n_irin);
      chk($sformatf("row%0d_pcin_cnt", r), n_pcin, 1);
      chk($sformatf("row%0d_mdread_cnt", r), n_mdread, rows[r].n_mdread);
      chk($sformatf("row%0d_fault", r), fault, rows[r].fault);
      chk($sformatf("row%0d_halted", r), halted, rows[r].halted);
      chk($sformatf("row%0d_final_strobes", r), strobes_only(sample()), '0);
      if (rows[r].halted) chk($sformatf("row%0d_halt_quiet", r), hlt_bad, 0);
    end

    // Reset asserted mid-T4 of ADD R3,R1,R2 must clear outputs before the next edge.
    do_reset();
    IR = 32'h19890000; run = 1'b1; mem_ready = 1'b1;
    tick();
    repeat (4) tick();
    #1;
    e = '0; e.sel = 4'd2; e.r_out = 1; e.alu = 4'b0011; e.zl_in = 1;
    chk("mid_t4_vector", sample(), e);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", sample(), '0);
    #1 reset = 1'b0;
    tick();
    e = '0; e.pc_out = 1; e.mar_in = 1; e.zl_in = 1; e.alu = 4'd1;
    chk("t0_after_reset", sample(), e);

    // Random back-to-back stream of legal instructions.
    do_reset();
    cq.delete();
    for (int i = 0; i < 30; i++) begin
      int          k;
      logic [31:0] rnd;
      logic [4:0]  op;
      k   = $urandom_range(0, 10);
      op  = (k < 9) ? 5'(3 + k) : 5'(14 + k - 9);
      rnd = $urandom();
      add_instr({op, rnd[26:0]}, $urandom_range(0, 5), i == 29);
    end
    run = 1'b1;
    tick();
    foreach (cq[i]) begin
      if (cq[i].new_ir) IR = cq[i].ir;
      mem_ready = cq[i].mr;
      run       = cq[i].rn;
      #1;
      chk($sformatf("stream_cycle%0d", i), sample(), cq[i].o);
      tick();
    end
    run = 1'b0;
    #1;
    chk("stream_idle", sample(), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
